// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch: 4-halfword queue fed by a one-outstanding imem FSM; requests issue combinationally from IDLE, decoder stalls via dec_ready.
// Define IFQ_BYPASS_EN to forward a response into an empty queue to the decoder in the same cycle (default: visible the cycle after).
module inst_fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          IFQ_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic [31:0] flush_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        ir_valid,
   output logic        ir_is32,
   output logic [15:0] ir_q0,
   output logic [15:0] ir_q1,
   output logic [31:0] pc,
   input  logic        dec_ready
);

   localparam int PW = $clog2(IFQ_DEPTH);
   localparam int CW = $clog2(IFQ_DEPTH + 1);
   localparam logic [CW-1:0] ONE      = CW'(1);
   localparam logic [CW-1:0] TWO      = CW'(2);
   localparam logic [CW-1:0] REQ_MAX  = CW'(IFQ_DEPTH - 2);

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t        state;
   logic [15:0]   mem [IFQ_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [31:0]   fetch_addr;
   logic          skip_low;

   logic [1:0]    push_n;
   logic [15:0]   push_h0;
   logic [15:0]   push_h1;
   logic [CW-1:0] view_cnt;
   logic [15:0]   view_h0;
   logic [15:0]   view_h1;
   logic [PW-1:0] rd_ptr1;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] wr_ptr1;
   logic          is32_enc;
   logic          consume;
   logic [1:0]    pop_n;

   assign rd_ptr1 = rd_ptr + 1'b1;
   assign wr_ptr  = rd_ptr + PW'(count);
   assign wr_ptr1 = wr_ptr + 1'b1;

   // A response after a flush to an odd halfword keeps only its upper half.
   always_comb begin
      push_n  = 2'd0;
      push_h0 = imem_rdata[15:0];
      push_h1 = imem_rdata[31:16];
      if ((state == WAIT) && imem_rvalid && !flush) begin
         if (skip_low) begin
            push_n  = 2'd1;
            push_h0 = imem_rdata[31:16];
         end else begin
            push_n  = 2'd2;
         end
      end
   end

   always_comb begin
      view_cnt = count;
      view_h0  = mem[rd_ptr];
      view_h1  = mem[rd_ptr1];
`ifdef IFQ_BYPASS_EN
      if ((count == '0) && (push_n != 2'd0)) begin
         view_cnt = CW'(push_n);
         view_h0  = push_h0;
         view_h1  = push_h1;
      end
`endif
   end

   assign is32_enc  = (view_h0[15:11] == 5'b11101) || (view_h0[15:11] == 5'b11110) ||
                      (view_h0[15:11] == 5'b11111);
   assign ir_is32   = (view_cnt >= ONE) && is32_enc;
   assign ir_valid  = ir_is32 ? (view_cnt >= TWO) : (view_cnt >= ONE);
   assign ir_q0     = (view_cnt >= ONE) ? view_h0 : 16'h0000;
   assign ir_q1     = (view_cnt >= TWO) ? view_h1 : 16'h0000;
   assign consume   = ir_valid && dec_ready && !flush;
   assign pop_n     = consume ? (ir_is32 ? 2'd2 : 2'd1) : 2'd0;

   // Requests only when two free slots exist, so a full response always fits.
   assign imem_req  = rst_n && (state == IDLE) && (count <= REQ_MAX) && !flush;
   assign imem_addr = fetch_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rd_ptr     <= '0;
         count      <= '0;
         pc         <= RESET_PC;
         fetch_addr <= {RESET_PC[31:2], 2'b00};
         skip_low   <= RESET_PC[1];
         for (int i = 0; i < IFQ_DEPTH; i++) begin
            mem[i] <= 16'h0000;
         end
      end else if (flush) begin
         rd_ptr     <= '0;
         count      <= '0;
         pc         <= flush_addr & 32'hFFFF_FFFE;
         fetch_addr <= flush_addr & 32'hFFFF_FFFC;
         skip_low   <= flush_addr[1];
         // A response landing with the flush settles the outstanding request; DROP must not wait for another.
         case (state)
            WAIT:    state <= imem_rvalid ? IDLE : DROP;
            DROP:    state <= imem_rvalid ? IDLE : DROP;
            default: state <= IDLE;
         endcase
      end else begin
         if (push_n != 2'd0) begin
            mem[wr_ptr] <= push_h0;
            if (push_n == 2'd2) begin
               mem[wr_ptr1] <= push_h1;
            end
            fetch_addr <= fetch_addr + 32'd4;
            skip_low   <= 1'b0;
         end
         rd_ptr <= rd_ptr + PW'(pop_n);
         count  <= count + CW'(push_n) - CW'(pop_n);
         pc     <= pc + {29'd0, pop_n, 1'b0};
         case (state)
            IDLE:    if (imem_req) state <= WAIT;
            WAIT:    if (imem_rvalid) state <= IDLE;
            DROP:    if (imem_rvalid) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
